// File: rtl/rs_syndrome_seq_if.sv
// Handshake bundle for rs_syndrome_seq: symbol input stream and syndrome output stream.
// master = upstream/downstream environment view, slave = syndrome calculator view.
interface rs_syndrome_seq_if #(
    parameter int SYMBOL_WIDTH = 3,
    parameter int NSYN         = 2
);
    logic                         in_valid;
    logic                         in_ready;
    logic                         in_sof;
    logic [SYMBOL_WIDTH-1:0]      in_symbol;
    logic                         syn_valid;
    logic                         syn_ready;
    logic [NSYN*SYMBOL_WIDTH-1:0] syn;
    logic                         syn_nonzero;
    logic [15:0]                  err_count;

    modport master (
        output in_valid, in_sof, in_symbol, syn_ready,
        input  in_ready, syn_valid, syn, syn_nonzero, err_count
    );

    modport slave (
        input  in_valid, in_sof, in_symbol, syn_ready,
        output in_ready, syn_valid, syn, syn_nonzero, err_count
    );
endinterface

// File: rtl/rs_syndrome_seq.sv
// Streaming Reed-Solomon syndrome calculator: S_j = r(alpha^j), j=1..NSYN, by Horner's rule.
// Define RS_SYN_ERR_CNT_EN to add a saturating count of codewords with nonzero syndrome.
module rs_syndrome_seq #(
    parameter int                    SYMBOL_WIDTH = 3,
    parameter int                    N            = 7,
    parameter int                    K            = 5,
    parameter int                    NSYN         = N - K,
    parameter logic [SYMBOL_WIDTH:0] PRIM_POLY    = 4'b1011
) (
    input logic              clk,
    input logic              rst_n,
    rs_syndrome_seq_if.slave bus
);
    localparam int          CW    = $clog2(N + 1);
    localparam int unsigned ORDER = (1 << SYMBOL_WIDTH) - 1;

    typedef logic [SYMBOL_WIDTH-1:0] sym_t;
    typedef enum logic {ACCUM, HOLD} state_t;

    // Shift-and-add multiply, reducing by PRIM_POLY whenever x^m appears.
    function automatic sym_t gf_mul(input sym_t a, input sym_t b);
        sym_t p;
        sym_t x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < SYMBOL_WIDTH; i++) begin
            if (b[i]) p = p ^ x;
            x = x[SYMBOL_WIDTH-1] ? ((x << 1) ^ PRIM_POLY[SYMBOL_WIDTH-1:0]) : (x << 1);
        end
        return p;
    endfunction

    function automatic sym_t gf_alpha_pow(input int unsigned e);
        sym_t r;
        r = sym_t'(1);
        for (int unsigned i = 0; i < e % ORDER; i++) r = gf_mul(r, sym_t'(2));
        return r;
    endfunction

    state_t                       state_q, state_d;
    logic [CW-1:0]                count_q, count_d;
    logic [NSYN*SYMBOL_WIDTH-1:0] syn_q, syn_next;
    logic                         accept;
    logic                         start;

    for (genvar j = 0; j < NSYN; j++) begin : g_syn
        localparam sym_t ALPHA_J = gf_alpha_pow(j + 1);
        assign syn_next[j*SYMBOL_WIDTH +: SYMBOL_WIDTH] =
            gf_mul(syn_q[j*SYMBOL_WIDTH +: SYMBOL_WIDTH], ALPHA_J) ^ bus.in_symbol;
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        bus.in_ready  = (state_q == ACCUM);
        bus.syn_valid = (state_q == HOLD);
        accept        = bus.in_valid && (state_q == ACCUM);
        // A mid-frame in_sof discards the partial frame and restarts at count 1.
        start         = (count_q == '0) || bus.in_sof;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    count_d = start ? CW'(1) : count_q + CW'(1);
                    if (count_d == CW'(N)) begin
                        state_d = HOLD;
                        count_d = '0;
                    end
                end
            end
            HOLD: begin
                if (bus.syn_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            count_q <= '0;
            syn_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (accept) syn_q <= start ? {NSYN{bus.in_symbol}} : syn_next;
        end
    end

    assign bus.syn         = syn_q;
    assign bus.syn_nonzero = |syn_q;

`ifdef RS_SYN_ERR_CNT_EN
    logic [15:0] err_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else if (bus.syn_valid && bus.syn_ready && bus.syn_nonzero && (err_count_q != '1)) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end

    assign bus.err_count = err_count_q;
`else
    assign bus.err_count = '0;
`endif
endmodule

// File: doc/rs_syndrome_seq.md
Name: rs_syndrome_seq

Overview:
Streaming Reed-Solomon syndrome calculator, parametrised over GF(2^m) symbol width, codeword length and syndrome count; generalises the fixed 3-bit, (7,5) combinational parity-check computation.
Accepts one received symbol per cycle over a valid/ready handshake and accumulates all syndromes S_j = r(alpha^j), j=1..NSYN, by Horner's rule.
Presents the syndrome vector plus a nonzero flag to the downstream error locator (Berlekamp-Massey / Chien stages) over a second valid/ready handshake.

Parameters:
SYMBOL_WIDTH, 3, bits per GF(2^m) symbol (m)
N, 7, codeword length in symbols (2..2^m-1)
K, 5, message length in symbols (K < N)
NSYN, N-K, number of syndromes (2T)
PRIM_POLY, 4'b1011, primitive polynomial incl. x^m term (x^3+x+1); alpha = 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_symbol valid
in_ready  out  1  block can accept a symbol
in_sof  in  1  first symbol of codeword; qualified by in_valid&&in_ready
in_symbol  in  SYMBOL_WIDTH  received symbol; first symbol = coefficient of x^(N-1)
syn_valid  out  1  syndrome vector valid
syn_ready  in  1  downstream accepts syndromes
syn  out  NSYN*SYMBOL_WIDTH  S_(j+1) in bits [j*SYMBOL_WIDTH +: SYMBOL_WIDTH]
syn_nonzero  out  1  OR of all syndrome bits (errors detected)
err_count  out  16  codewords with nonzero syndrome (see optional feature)

Behaviour:
- Reset (async, rst_n=0): state=ACCUM, symbol count=0, all syndrome accumulators=0, syn_valid=0, syn_nonzero=0, err_count=0. in_ready=1 after reset deasserts.
- States: ACCUM (in_ready=1, syn_valid=0), HOLD (in_ready=0, syn_valid=1).
- Accept = in_valid && in_ready. On accept in ACCUM:
  - if count==0 or in_sof: S_j <= in_symbol for all j; count <= 1 (in_sof mid-frame discards partial frame, restarts).
  - else: S_j <= gfmul(S_j, alpha^j) XOR in_symbol; count <= count+1.
  - when the accepted symbol makes count reach N: go HOLD, count <= 0.
- Constants alpha^j computed at elaboration from PRIM_POLY; gfmul is a combinational GF(2^m) multiply reducing by PRIM_POLY; exponents taken mod 2^m-1.
- Latency: syn_valid rises the cycle after the N-th symbol is accepted; syn/syn_nonzero registered, stable throughout HOLD.
- HOLD: on syn_valid && syn_ready -> ACCUM next cycle; syn_valid drops; in_ready returns 1 same edge (one bubble cycle between frames). syn value remains unchanged until next frame overwrites accumulators.
- in_sof with count==0 is redundant and harmless; in_sof absent on first symbol still starts frame.
- Inputs while in_ready=0 are ignored; in_valid may stay high without effect.
- N=... count width = clog2(N+1).
- Reset mid-frame or mid-HOLD: all state cleared, pending syndrome lost, no syn_valid emitted.

Optional Feature:
RS_SYN_ERR_CNT_EN: when defined, err_count increments (saturating at 16'hFFFF) on each syn handshake where syn_nonzero=1; cleared only by reset. When undefined, err_count is tied to 16'h0000 and no counter logic exists; port list unchanged.

Test Plan:
- Defaults, 7 symbols all 0 -> syn_valid one cycle after 7th accept, syn S1=0, S2=0, syn_nonzero=0.
- Symbols 1,0,0,0,0,0,0 (error at x^6) -> S1=3'd5 (alpha^6), S2=3'd7 (alpha^12=alpha^5), syn_nonzero=1.
- Symbols 0,0,0,0,0,0,1 (x^0) -> S1=1, S2=1; with RS_SYN_ERR_CNT_EN, after both frames err_count=2.
- Hold syn_ready=0 for 5 cycles after frame -> in_ready=0, syn stable, extra in_valid symbols ignored; syn_ready=1 -> next frame accepted correctly after one bubble.
- Send 3 symbols, then in_sof with frame 1,0,0,0,0,0,0 -> partial frame discarded, S1=5, S2=7.
- Assert rst_n=0 after 4 symbols -> outputs zero immediately; next full all-zero frame yields S1=S2=0, err_count unchanged at 0.
